// File: rtl/pc_epc_unit.sv
// pc_epc_unit
//   Program counter and exception PC registers of the multicycle MIPS
//   datapath. Sits directly downstream of the PC source mux.
//   - RUN: PC loads PCSrc_output on PCWrite, or on PCWriteCond when the
//     selected branch condition holds. Misaligned targets are rejected and
//     flagged with a one-cycle pc_misaligned pulse.
//   - Exception sequence RUN -> EXC_SAVE -> EXC_LOAD -> RUN: save PC-EPC_OFFSET
//     into EPC, then wait for vec_valid and load the vector from the mux.
//
//   Optional feature macro: PC_BRANCH_STATS_EN
//     defined     : branch_taken_count / branch_total_count are live counters
//     not defined : both count ports are tied to zero
//
// Ports
//   clk                 in   1           rising-edge clock
//   reset               in   1           asynchronous active-high reset
//   PCWrite             in   1           unconditional PC load request
//   PCWriteCond         in   1           branch-qualified PC load request
//   branch_op           in   2           00 beq, 01 bne, 10 bgt, 11 ble
//   zero                in   1           ALU zero flag
//   gt                  in   1           ALU greater-than flag
//   PCSrc_output        in   32          next-PC value from PC source mux
//   exc_req             in   1           exception request pulse
//   vec_valid           in   1           exception vector on PCSrc_output
//   PC_output           out  32          current PC
//   EPC_output          out  32          saved exception PC
//   exc_busy            out  1           exception sequence in progress
//   pc_misaligned       out  1           one-cycle pulse on rejected load
//   branch_taken_count  out  STAT_WIDTH  taken conditional branches
//   branch_total_count  out  STAT_WIDTH  evaluated conditional branches
module pc_epc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EPC_OFFSET   = 32'd4,
  parameter int          STAT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  PCWrite,
  input  logic                  PCWriteCond,
  input  logic [1:0]            branch_op,
  input  logic                  zero,
  input  logic                  gt,
  input  logic [31:0]           PCSrc_output,
  input  logic                  exc_req,
  input  logic                  vec_valid,
  output logic [31:0]           PC_output,
  output logic [31:0]           EPC_output,
  output logic                  exc_busy,
  output logic                  pc_misaligned,
  output logic [STAT_WIDTH-1:0] branch_taken_count,
  output logic [STAT_WIDTH-1:0] branch_total_count
);

  typedef enum logic [1:0] {RUN, EXC_SAVE, EXC_LOAD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, epc;
  logic        mis;
  logic        cond_ok;
  logic        pc_load;
  logic        epc_save;
  logic        mis_nxt;

  function automatic logic branch_cond(input logic [1:0] op,
                                       input logic z, input logic g);
    case (op)
      2'b00:   branch_cond = z;
      2'b01:   branch_cond = ~z;
      2'b10:   branch_cond = g;
      default: branch_cond = ~g;
    endcase
  endfunction

  assign cond_ok = branch_cond(branch_op, zero, gt);

  always_comb begin
    state_nxt = state;
    pc_load   = 1'b0;
    epc_save  = 1'b0;
    mis_nxt   = 1'b0;
    case (state)
      RUN: begin
        // An exception request pre-empts any load in the same cycle.
        if (exc_req) begin
          state_nxt = EXC_SAVE;
        end else if (PCWrite | (PCWriteCond & cond_ok)) begin
          if (PCSrc_output[1:0] != 2'b00) mis_nxt = 1'b1;
          else                            pc_load = 1'b1;
        end
      end
      EXC_SAVE: begin
        epc_save  = 1'b1;
        state_nxt = EXC_LOAD;
      end
      EXC_LOAD: begin
        // The vector is trusted: no alignment check on this load.
        if (vec_valid) begin
          pc_load   = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      pc    <= RESET_VECTOR;
      epc   <= 32'h0000_0000;
      mis   <= 1'b0;
    end else begin
      state <= state_nxt;
      mis   <= mis_nxt;
      if (pc_load)  pc  <= PCSrc_output;
      // Wraps modulo 2^32, so PC=0 saves 32'hFFFF_FFFC.
      if (epc_save) epc <= pc - EPC_OFFSET;
    end
  end

  assign PC_output     = pc;
  assign EPC_output    = epc;
  assign exc_busy      = (state != RUN);
  assign pc_misaligned = mis;

`ifdef PC_BRANCH_STATS_EN
  logic                  branch_eval;
  logic [STAT_WIDTH-1:0] taken_cnt, total_cnt;

  // Only a genuine conditional branch in RUN is evaluated; a taken branch
  // counts even when its target is rejected as misaligned.
  assign branch_eval = (state == RUN) & PCWriteCond & ~PCWrite & ~exc_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_cnt <= '0;
      total_cnt <= '0;
    end else if (branch_eval) begin
      total_cnt <= total_cnt + STAT_WIDTH'(1);
      if (cond_ok) taken_cnt <= taken_cnt + STAT_WIDTH'(1);
    end
  end

  assign branch_taken_count = taken_cnt;
  assign branch_total_count = total_cnt;
`else
  assign branch_taken_count = '0;
  assign branch_total_count = '0;
`endif

endmodule

// File: tb/tb_pc_epc_unit.sv
module tb_pc_epc_unit;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          pcw, pcwc, zero, gt, exc, vv;
  logic [1:0]    bop;
  logic [31:0]   src;
  logic [31:0]   pc_o, epc_o;
  logic          busy, mis;
  logic [SW-1:0] taken, total;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        busy;
    logic        mis;
    logic [15:0] tk;
    logic [15:0] tot;
  } exp_t;

  exp_t sb[$];

  pc_epc_unit #(.RESET_VECTOR(32'h0), .EPC_OFFSET(32'd4), .STAT_WIDTH(SW)) dut (
    .clk(clk), .reset(rst), .PCWrite(pcw), .PCWriteCond(pcwc),
    .branch_op(bop), .zero(zero), .gt(gt), .PCSrc_output(src),
    .exc_req(exc), .vec_valid(vv), .PC_output(pc_o), .EPC_output(epc_o),
    .exc_busy(busy), .pc_misaligned(mis),
    .branch_taken_count(taken), .branch_total_count(total)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld,
                     input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s got=%h want=%h", nm, fld, act, req);
    end
  endtask

  // Monitor: one expectation per clock, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.nm, "pc",    pc_o,  e.pc);
        chk(e.nm, "epc",   epc_o, e.epc);
        chk(e.nm, "busy",  {31'b0, busy}, {31'b0, e.busy});
        chk(e.nm, "mis",   {31'b0, mis},  {31'b0, e.mis});
        chk(e.nm, "taken", {16'b0, taken}, {16'b0, e.tk});
        chk(e.nm, "total", {16'b0, total}, {16'b0, e.tot});
      end
    end
  end

  task automatic step(input string nm, input logic r,
                      input logic i_pcw, input logic i_pcwc, input logic [1:0] i_bop,
                      input logic i_z, input logic i_g, input logic [31:0] i_src,
                      input logic i_exc, input logic i_vv,
                      input logic [31:0] e_pc, input logic [31:0] e_epc,
                      input logic e_busy, input logic e_mis,
                      input logic [15:0] e_tk, input logic [15:0] e_tot);
    exp_t e;
    @(negedge clk);
    rst = r; pcw = i_pcw; pcwc = i_pcwc; bop = i_bop; zero = i_z; gt = i_g;
    src = i_src; exc = i_exc; vv = i_vv;
    e.nm = nm; e.pc = e_pc; e.epc = e_epc; e.busy = e_busy; e.mis = e_mis;
`ifdef PC_BRANCH_STATS_EN
    e.tk = e_tk; e.tot = e_tot;
`else
    e.tk = 16'd0; e.tot = 16'd0;
`endif
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b1; pcw = 0; pcwc = 0; bop = 0; zero = 0; gt = 0;
    src = 0; exc = 0; vv = 0;
    //    name       rst pcw pcwc bop   z  g  src           exc vv  pc            epc           bsy mis tk tot
    step("reset",    1, 0, 0, 2'b00, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         0, 0, 0, 0);
    step("pcw40",    0, 1, 0, 2'b00, 0, 0, 32'h40,        0, 0, 32'h40,        32'h0,         0, 0, 0, 0);
    step("pcw100",   0, 1, 0, 2'b00, 0, 0, 32'h100,       0, 0, 32'h100,       32'h0,         0, 0, 0, 0);
    step("bne_z1",   0, 0, 1, 2'b01, 1, 0, 32'h80,        0, 0, 32'h100,       32'h0,         0, 0, 0, 1);
    step("bne_z0",   0, 0, 1, 2'b01, 0, 0, 32'h80,        0, 0, 32'h80,        32'h0,         0, 0, 1, 2);
    step("beq_z1",   0, 0, 1, 2'b00, 1, 0, 32'h88,        0, 0, 32'h88,        32'h0,         0, 0, 2, 3);
    step("bgt_g0",   0, 0, 1, 2'b10, 0, 0, 32'h90,        0, 0, 32'h88,        32'h0,         0, 0, 2, 4);
    step("ble_g0",   0, 0, 1, 2'b11, 0, 0, 32'h94,        0, 0, 32'h94,        32'h0,         0, 0, 3, 5);
    step("both",     0, 1, 1, 2'b00, 0, 0, 32'h98,        0, 0, 32'h98,        32'h0,         0, 0, 3, 5);
    step("mis",      0, 1, 0, 2'b00, 0, 0, 32'h102,       0, 0, 32'h98,        32'h0,         0, 1, 3, 5);
    step("mis_clr",  0, 0, 0, 2'b00, 0, 0, 32'h0,         0, 0, 32'h98,        32'h0,         0, 0, 3, 5);
    step("bmis",     0, 0, 1, 2'b00, 1, 0, 32'h9A,        0, 0, 32'h98,        32'h0,         0, 1, 4, 6);
    step("bmis_clr", 0, 0, 0, 2'b00, 0, 0, 32'h0,         0, 0, 32'h98,        32'h0,         0, 0, 4, 6);
    step("pcw204",   0, 1, 0, 2'b00, 0, 0, 32'h204,       0, 0, 32'h204,       32'h0,         0, 0, 4, 6);
    step("exc",      0, 1, 0, 2'b00, 0, 0, 32'h300,       1, 0, 32'h204,       32'h0,         1, 0, 4, 6);
    step("save",     0, 0, 0, 2'b00, 0, 0, 32'h0,         0, 0, 32'h204,       32'h200,       1, 0, 4, 6);
    step("wait1",    0, 1, 0, 2'b00, 0, 0, 32'h500,       1, 0, 32'h204,       32'h200,       1, 0, 4, 6);
    step("wait2",    0, 0, 1, 2'b00, 1, 0, 32'h504,       0, 0, 32'h204,       32'h200,       1, 0, 4, 6);
    step("vec",      0, 0, 0, 2'b00, 0, 0, 32'hFF,        0, 1, 32'hFF,        32'h200,       0, 0, 4, 6);
    step("post",     0, 0, 0, 2'b00, 0, 0, 32'h0,         0, 0, 32'hFF,        32'h200,       0, 0, 4, 6);
    step("pc0",      0, 1, 0, 2'b00, 0, 0, 32'h0,         0, 0, 32'h0,         32'h200,       0, 0, 4, 6);
    step("exc0",     0, 0, 0, 2'b00, 0, 0, 32'h0,         1, 0, 32'h0,         32'h200,       1, 0, 4, 6);
    step("save0",    0, 0, 0, 2'b00, 0, 0, 32'h0,         0, 0, 32'h0,         32'hFFFF_FFFC, 1, 0, 4, 6);
    step("ign_ld",   0, 1, 0, 2'b00, 0, 0, 32'h10,        1, 0, 32'h0,         32'hFFFF_FFFC, 1, 0, 4, 6);
    step("vec0",     0, 0, 0, 2'b00, 0, 0, 32'h44,        0, 1, 32'h44,        32'hFFFF_FFFC, 0, 0, 4, 6);
    step("run0",     0, 0, 0, 2'b00, 0, 0, 32'h0,         0, 0, 32'h44,        32'hFFFF_FFFC, 0, 0, 4, 6);
    step("exc1",     0, 0, 0, 2'b00, 0, 0, 32'h0,         1, 0, 32'h44,        32'hFFFF_FFFC, 1, 0, 4, 6);
    step("save1",    0, 0, 0, 2'b00, 0, 0, 32'h0,         0, 0, 32'h44,        32'h40,        1, 0, 4, 6);
    step("rst_mid",  1, 0, 0, 2'b00, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         0, 0, 0, 0);
    step("after",    0, 0, 0, 2'b00, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         0, 0, 0, 0);
    step("pcw8",     0, 1, 0, 2'b00, 0, 0, 32'h8,         0, 0, 32'h8,         32'h0,         0, 0, 0, 0);
    @(negedge clk);
    pcw = 0;
    repeat (2) @(negedge clk);
    chk("drain", "left", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
